// File: rtl/jxli_fp8mul.sv
// rtl/jxli_fp8mul.sv - serial-load FP8 (1/4/3, bias 7) multiplier for a pin-limited tile
//
// Ports:
//   io_in[0]   clock, all state updates on its rising edge
//   io_in[1]   reset, asynchronous active-high
//   io_in[2]   enable, a nibble is captured only when high
//   io_in[6:3] data nibble (a[7:4], a[3:0], b[7:4], b[3:0] in that order)
//   io_in[7]   ignored
//   io_out     FP8 product {sign, exp[3:0], man[2:0]}, 0 until the result is ready
module jxli_fp8mul (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [2:0] {
        A_HI = 3'd0,
        A_LO = 3'd1,
        B_HI = 3'd2,
        B_LO = 3'd3,
        MUL  = 3'd4,
        NORM = 3'd5,
        DONE = 3'd6
    } state_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] nib;
    logic       unused_pin;

    assign clk        = io_in[0];
    assign rst        = io_in[1];
    assign en         = io_in[2];
    assign nib        = io_in[6:3];
    assign unused_pin = io_in[7];

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        a;
    logic [7:0]        b;
    logic signed [5:0] ce;
    logic [7:0]        cm;
    logic              sign;
    logic              sp_flag;
    logic [7:0]        sp_res;

    // ------------------------------------------------------------------
    // Operand classification and MUL-stage values
    // ------------------------------------------------------------------
    logic       a_nan, a_inf, a_zero;
    logic       b_nan, b_inf, b_zero;
    logic       s_mul;
    logic       sp_flag_mul;
    logic [7:0] sp_res_mul;
    logic signed [5:0] ce_mul;
    logic [7:0] cm_mul;

    always_comb begin
        // Exponent 0 means zero; subnormal mantissas are flushed.
        a_zero = (a[6:3] == 4'h0);
        b_zero = (b[6:3] == 4'h0);
        a_inf  = (a[6:3] == 4'hF) && (a[2:0] == 3'b000);
        b_inf  = (b[6:3] == 4'hF) && (b[2:0] == 3'b000);
        a_nan  = (a[6:3] == 4'hF) && (a[2:0] != 3'b000);
        b_nan  = (b[6:3] == 4'hF) && (b[2:0] != 3'b000);
        s_mul  = a[7] ^ b[7];

        sp_flag_mul = 1'b0;
        sp_res_mul  = 8'h00;
        if (a_nan || b_nan) begin
            sp_flag_mul = 1'b1;
            sp_res_mul  = {s_mul, 4'hF, 3'b111};
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            sp_flag_mul = 1'b1;
            sp_res_mul  = {s_mul, 4'hF, 3'b111};
        end else if (a_inf || b_inf) begin
            sp_flag_mul = 1'b1;
            sp_res_mul  = {s_mul, 4'hF, 3'b000};
        end else if (a_zero || b_zero) begin
            sp_flag_mul = 1'b1;
            sp_res_mul  = {s_mul, 4'h0, 3'b000};
        end

        // Exponent sum stays within -7..23 before normalization, so six
        // signed bits are enough even after the two possible increments.
        ce_mul = $signed({2'b00, a[6:3]}) + $signed({2'b00, b[6:3]}) - 6'sd7;
        cm_mul = {4'b0001, a[2:0]} * {4'b0001, b[2:0]};
    end

    // ------------------------------------------------------------------
    // NORM-stage normalization and round-to-nearest-even
    // ------------------------------------------------------------------
    // cm holds the product with six fraction bits: value in [1,4).
    logic              shift;
    logic [2:0]        frac;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [3:0]        frac_rnd;
    logic              carry;
    logic signed [5:0] ce_fin;
    logic [7:0]        result;

    always_comb begin
        shift = cm[7];
        if (shift) begin
            frac   = cm[6:4];
            guard  = cm[3];
            sticky = |cm[2:0];
        end else begin
            frac   = cm[5:3];
            guard  = cm[2];
            sticky = |cm[1:0];
        end

        round_up = guard & (sticky | frac[0]);
        frac_rnd = {1'b0, frac} + {3'b000, round_up};
        // A carry out of the fraction means 1.111 rounded to 10.000; the
        // kept fraction bits are then all zero and the exponent bumps.
        carry    = frac_rnd[3];
        ce_fin   = ce + $signed({5'b00000, shift}) + $signed({5'b00000, carry});

        if (sp_flag) begin
            result = sp_res;
        end else if (ce_fin >= 6'sd15) begin
            result = {sign, 4'hF, 3'b000};
        end else if (ce_fin <= 6'sd0) begin
            result = {sign, 4'h0, 3'b000};
        end else begin
            result = {sign, ce_fin[3:0], frac_rnd[2:0]};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= A_HI;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            A_HI:    if (en) state_nxt = A_LO;
            A_LO:    if (en) state_nxt = B_HI;
            B_HI:    if (en) state_nxt = B_LO;
            B_LO:    if (en) state_nxt = MUL;
            MUL:     state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = A_HI;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a       <= 8'h00;
            b       <= 8'h00;
            ce      <= 6'sd0;
            cm      <= 8'h00;
            sign    <= 1'b0;
            sp_flag <= 1'b0;
            sp_res  <= 8'h00;
            io_out  <= 8'h00;
        end else begin
            case (state)
                A_HI: if (en) a[7:4] <= nib;
                A_LO: if (en) a[3:0] <= nib;
                B_HI: if (en) b[7:4] <= nib;
                B_LO: if (en) b[3:0] <= nib;
                MUL: begin
                    ce      <= ce_mul;
                    cm      <= cm_mul;
                    sign    <= s_mul;
                    sp_flag <= sp_flag_mul;
                    sp_res  <= sp_res_mul;
                end
                NORM: io_out <= result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jxli_fp8mul.sv
// tb/tb_jxli_fp8mul.sv - directed-vector bench for jxli_fp8mul
module tb_jxli_fp8mul;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       en    = 1'b0;
    logic [3:0] nib   = 4'h0;
    logic       spare = 1'b0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {spare, nib, en, rst, clk};

    jxli_fp8mul dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_asserts++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // One nibble with enable high, then 'gap' clocks with enable low and
    // junk on the data pins, which must not disturb anything.
    task automatic load_nib(input string tag, input logic [3:0] n, input int gap);
        en  = 1'b1;
        nib = n;
        tick();
        en    = 1'b0;
        nib   = 4'hA;
        spare = 1'b1;
        for (int i = 0; i < gap; i++) begin
            tick();
            check($sformatf("%s_gap", tag), io_out, 8'h00);
        end
        spare = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] want, input int gap);
        do_reset();
        load_nib(tag, a[7:4], gap);
        load_nib(tag, a[3:0], gap);
        load_nib(tag, b[7:4], gap);
        // Last nibble: keep enable high with junk data through MUL/NORM/DONE.
        en  = 1'b1;
        nib = b[3:0];
        tick();
        nib = 4'hF;
        tick();
        check($sformatf("%s_mul", tag), io_out, 8'h00);
        tick();
        check(tag, io_out, want);
        tick();
        tick();
        check($sformatf("%s_hold", tag), io_out, want);
        en = 1'b0;
    endtask

    initial begin
        #2;
        check("reset_out", io_out, 8'h00);

        run_op("overflow_0111", 8'h77, 8'h77, 8'h78, 0);
        run_op("neg30",         8'hD2, 8'h44, 8'hDF, 0);
        run_op("nan_x_inf",     8'hFA, 8'h78, 8'hFF, 0);
        run_op("inf_x_zero",    8'h78, 8'h00, 8'h7F, 0);
        run_op("sq_1p125",      8'h39, 8'h39, 8'h3A, 0);
        run_op("underflow",     8'h08, 8'h08, 8'h00, 0);
        run_op("underflow_gap", 8'h08, 8'h08, 8'h00, 3);
        run_op("neg30_gap",     8'hD2, 8'h44, 8'hDF, 3);
        run_op("tie_even_down", 8'h3C, 8'h3E, 8'h42, 0);
        run_op("tie_even_up",   8'h39, 8'h3C, 8'h3E, 0);
        run_op("round_up",      8'h3D, 8'h3D, 8'h43, 0);
        run_op("round_carry",   8'h39, 8'h3E, 8'h40, 0);
        run_op("neg_zero",      8'h80, 8'h38, 8'h80, 0);
        run_op("subnormal",     8'h05, 8'h38, 8'h00, 0);
        run_op("neg_inf",       8'hF8, 8'h38, 8'hF8, 0);
        run_op("ce_zero",       8'h08, 8'h30, 8'h00, 0);
        run_op("ce_one",        8'h08, 8'h38, 8'h08, 0);
        run_op("ce_fourteen",   8'h70, 8'h38, 8'h70, 0);
        run_op("ce_fifteen",    8'h70, 8'h40, 8'h78, 0);

        // Asynchronous reset while DONE holds a nonzero result.
        run_op("pre_rst", 8'hD2, 8'h44, 8'hDF, 0);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_done", io_out, 8'h00);

        // Reset after two nibbles, then a fresh load must be clean.
        do_reset();
        load_nib("abort", 4'hF, 0);
        load_nib("abort", 4'hF, 0);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_mid", io_out, 8'h00);
        run_op("after_abort", 8'h40, 8'h38, 8'h40, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
